// File: rtl/combo_dialer_pkg.sv
// combo_dialer_pkg
//   Shared definitions for the combination-lock dialer.
//   - state_e : dialer FSM state encoding (also exported as a debug value)
//   - op_e    : host operation codes
//   - default timing constants and the counter-width helper used to size
//     the shared down-counter
package combo_dialer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_PULSE    = 3'd2,
    ST_WAIT     = 3'd3,
    ST_LOAD_NEW = 3'd4,
    ST_COMMIT   = 3'd5,
    ST_LOCKOUT  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    OP_UNLOCK = 2'b00,
    OP_CHANGE = 2'b01,
    OP_RELOCK = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  localparam int SETTLE_DEF  = 2;
  localparam int RESP_TO_DEF = 4;
  localparam int HOLD_DEF    = 8;

  // Width that holds the largest of the three cycle counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/combo_dialer_if.sv
// combo_dialer_if
//   Bundles the host request, lock status and dialer drive/status signals.
//   modport master : the dialer (drives code/pulses into the lock, reports
//                    status to the host)
//   modport slave  : the environment (host + lock) around the dialer
//   Handshake: start is a level request sampled only while the dialer is idle
//   and not reporting done; once accepted, the dialer owns the operation until
//   it raises done for exactly one cycle (success valid with done and held
//   until the next done). There is no back-pressure and no queueing.
interface combo_dialer_if;
  logic                     start;
  logic [1:0]               op;
  logic [3:0]               code_in;
  logic [3:0]               new_code;
  logic                     open_i;
  logic                     new_i;
  logic                     alarm_i;
  logic [3:0]               code_o;
  logic                     enter_pulse;
  logic                     change_pulse;
  logic                     busy;
  logic                     done;
  logic                     success;
  logic                     fail_pending;
  logic                     lockout;
  combo_dialer_pkg::state_e state_dbg;

  modport master (
    input  start, op, code_in, new_code, open_i, new_i, alarm_i,
    output code_o, enter_pulse, change_pulse, busy, done, success,
           fail_pending, lockout, state_dbg
  );

  modport slave (
    output start, op, code_in, new_code, open_i, new_i, alarm_i,
    input  code_o, enter_pulse, change_pulse, busy, done, success,
           fail_pending, lockout, state_dbg
  );
endinterface

// File: rtl/combo_dialer_timer.sv
// dial_timer
//   Loadable saturating down-counter with a zero flag, shared by every timed
//   phase of the dialer (settle, response timeout, hold).
//   clock, resetn : clock and synchronous active-low reset
//   load          : load load_val this cycle (wins over counting)
//   load_val      : value to load
//   zero          : counter currently at zero
//   Loading N-1 makes zero appear after exactly N cycles in the owning state.
module dial_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/combo_dialer.sv
// combo_dialer
//   Initiator for a combination lock: presents a 4-bit code, issues one-cycle
//   enter/change strobes and watches the lock's open/new/alarm status to run
//   unlock, code-change and relock operations for a host.
//   clock, resetn : clock and synchronous active-low reset
//   bus (master)  : host request (start/op/code_in/new_code), lock status
//                   (open_i/new_i/alarm_i), lock drive (code_o, enter_pulse,
//                   change_pulse), host status (busy/done/success/
//                   fail_pending/lockout) and state_dbg
//   Build option COMBO_DIALER_RELOCK_EN: a successful unlock holds the lock
//   open for HOLD cycles, then relocks it before reporting done.
module combo_dialer
  import combo_dialer_pkg::*;
#(
  parameter int SETTLE  = SETTLE_DEF,
  parameter int RESP_TO = RESP_TO_DEF,
  parameter int HOLD    = HOLD_DEF
) (
  input logic            clock,
  input logic            resetn,
  combo_dialer_if.master bus
);
  localparam int CNT_W = cnt_width(SETTLE, RESP_TO, HOLD);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] RESP_LD   = CNT_W'(RESP_TO - 1);
  // COMMIT spans the enter strobe plus one cycle for the lock to react.
  localparam logic [CNT_W-1:0] COMMIT_LD = CNT_W'(1);
`ifdef COMBO_DIALER_RELOCK_EN
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD - 1);
`endif

  state_e     state_d, state_q;
  op_e        op_d, op_q;
  logic [3:0] code_d, code_q;
  logic [3:0] newc_d, newc_q;
  logic       enter_d, enter_q;
  logic       change_d, change_q;
  logic       done_d, done_q;
  logic       success_d, success_q;
  logic       fail_d, fail_q;
  logic       relock_d, relock_q;   // unlock has moved on to its auto-relock leg

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  dial_timer #(.W(CNT_W)) u_timer (
    .clock    (clock),
    .resetn   (resetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    code_d    = code_q;
    newc_d    = newc_q;
    enter_d   = 1'b0;
    change_d  = 1'b0;
    done_d    = 1'b0;
    success_d = success_q;
    fail_d    = fail_q;
    relock_d  = relock_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    // An alarm overrides everything, whatever the dialer was doing.
    if (bus.alarm_i && state_q != ST_LOCKOUT) begin
      state_d   = ST_LOCKOUT;
      done_d    = 1'b1;
      success_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // The cycle that reports done is not a window for a new request.
          if (bus.start && !done_q && op_e'(bus.op) != OP_RSVD) begin
            op_d     = op_e'(bus.op);
            newc_d   = bus.new_code;
            relock_d = 1'b0;
            // Relock re-uses whatever code is already on the lock input.
            if (op_e'(bus.op) != OP_RELOCK) code_d = bus.code_in;
            state_d  = ST_SETTLE;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LD;
          end
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            state_d  = ST_PULSE;
            change_d = (op_q == OP_CHANGE);
            enter_d  = (op_q != OP_CHANGE);
          end
        end
        ST_PULSE: begin
          state_d  = ST_WAIT;
          tmr_load = 1'b1;
          tmr_val  = RESP_LD;
        end
        ST_WAIT: begin
          if (relock_q || op_q == OP_RELOCK) begin
            if (!bus.open_i) begin
              state_d = ST_IDLE; done_d = 1'b1; success_d = 1'b1;
            end else if (tmr_zero) begin
              state_d = ST_IDLE; done_d = 1'b1; success_d = 1'b0;
            end
          end else if (op_q == OP_UNLOCK) begin
            if (bus.open_i) begin
              fail_d = 1'b0;
`ifdef COMBO_DIALER_RELOCK_EN
              relock_d = 1'b1;
              state_d  = ST_SETTLE;
              tmr_load = 1'b1;
              tmr_val  = HOLD_LD;
`else
              state_d   = ST_IDLE;
              done_d    = 1'b1;
              success_d = 1'b1;
`endif
            end else if (tmr_zero) begin
              state_d = ST_IDLE; done_d = 1'b1; success_d = 1'b0; fail_d = 1'b1;
            end
          end else begin
            if (bus.new_i) begin
              state_d  = ST_LOAD_NEW;
              code_d   = newc_q;
              tmr_load = 1'b1;
              tmr_val  = SETTLE_LD;
            end else if (tmr_zero) begin
              state_d = ST_IDLE; done_d = 1'b1; success_d = 1'b0; fail_d = 1'b1;
            end
          end
        end
        ST_LOAD_NEW: begin
          if (tmr_zero) begin
            state_d  = ST_COMMIT;
            enter_d  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = COMMIT_LD;
          end
        end
        ST_COMMIT: begin
          // Leaving change mode confirms the lock took the new code.
          if (tmr_zero) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (!bus.new_i) begin
              success_d = 1'b1;
              fail_d    = 1'b0;
            end else begin
              success_d = 1'b0;
            end
          end
        end
        ST_LOCKOUT: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_UNLOCK;
      code_q    <= '0;
      newc_q    <= '0;
      enter_q   <= 1'b0;
      change_q  <= 1'b0;
      done_q    <= 1'b0;
      success_q <= 1'b0;
      fail_q    <= 1'b0;
      relock_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      code_q    <= code_d;
      newc_q    <= newc_d;
      enter_q   <= enter_d;
      change_q  <= change_d;
      done_q    <= done_d;
      success_q <= success_d;
      fail_q    <= fail_d;
      relock_q  <= relock_d;
    end
  end

  assign bus.code_o       = code_q;
  assign bus.enter_pulse  = enter_q;
  assign bus.change_pulse = change_q;
  assign bus.done         = done_q;
  assign bus.success      = success_q;
  assign bus.fail_pending = fail_q;
  assign bus.lockout      = (state_q == ST_LOCKOUT);
  assign bus.busy         = (state_q != ST_IDLE) && (state_q != ST_LOCKOUT);
  assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_combo_dialer.sv
// tb_combo_dialer
//   Directed bench for combo_dialer with a behavioural lock model (reset code
//   0110, one wrong attempt marks an error, a second raises the alarm).
//   Pulse codes are checked against an expected queue; everything else
//   against hand-computed values. Honours COMBO_DIALER_RELOCK_EN.
module tb_combo_dialer;
  import combo_dialer_pkg::*;

`ifdef COMBO_DIALER_RELOCK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  combo_dialer_if bus ();

  combo_dialer dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // ---------------- lock model ----------------
  localparam logic [2:0] LK_LOCKED = 3'd0, LK_OPEN = 3'd1, LK_NEW = 3'd2,
                         LK_ERR = 3'd3, LK_ALARM = 3'd4;
  logic [2:0] lk_state;
  logic [3:0] lk_code;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      lk_state <= LK_LOCKED;
      lk_code  <= 4'b0110;
    end else begin
      case (lk_state)
        LK_LOCKED, LK_ERR:
          if (bus.enter_pulse || bus.change_pulse) begin
            if (bus.code_o == lk_code) lk_state <= bus.enter_pulse ? LK_OPEN : LK_NEW;
            else                       lk_state <= (lk_state == LK_ERR) ? LK_ALARM : LK_ERR;
          end
        LK_OPEN: if (bus.enter_pulse) lk_state <= LK_LOCKED;
        LK_NEW:
          if (bus.enter_pulse) begin
            lk_code  <= bus.code_o;
            lk_state <= LK_LOCKED;
          end
        default: ;
      endcase
    end
  end

  assign bus.open_i  = (lk_state == LK_OPEN);
  assign bus.new_i   = (lk_state == LK_NEW);
  assign bus.alarm_i = (lk_state == LK_ALARM);

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {bus.code_o, bus.enter_pulse, bus.change_pulse, bus.busy, bus.done,
            bus.success, bus.fail_pending, bus.lockout};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int   pulse_cyc, done_cyc, n_enter, n_change;
  logic got_done, got_success;

  // Issue one request and monitor until done (bounded by budget cycles).
  task automatic run_op(input logic [1:0] op, input logic [3:0] code,
                        input logic [3:0] nc, input bit hold_start, input int budget);
    logic [3:0] e;
    bus.op = op; bus.code_in = code; bus.new_code = nc; bus.start = 1'b1;
    tick();
    if (!hold_start) bus.start = 1'b0;
    pulse_cyc = -1; done_cyc = -1; n_enter = 0; n_change = 0;
    got_done = 1'b0; got_success = 1'b0;
    for (int c = 1; c <= budget && !got_done; c++) begin
      tick();
      if (bus.enter_pulse || bus.change_pulse) begin
        if (pulse_cyc < 0) pulse_cyc = c;
        e = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check("pulse_code", {28'd0, bus.code_o}, {28'd0, e});
        check("pulse_exclusive", {31'd0, bus.enter_pulse & bus.change_pulse}, 32'd0);
      end
      n_enter  += int'(bus.enter_pulse);
      n_change += int'(bus.change_pulse);
      if (bus.done) begin
        got_done = 1'b1; done_cyc = c; got_success = bus.success;
      end
    end
  endtask

  task automatic watch(input int n, output int act);
    act = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      act += int'(bus.enter_pulse) + int'(bus.change_pulse) + int'(bus.busy) + int'(bus.done);
    end
  endtask

  // ---------------- directed sequence ----------------
  int act;

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.code_in = '0; bus.new_code = '0;
    resetn = 1'b0;
    tick(); tick();
    check("reset_outs", {21'd0, outs()}, 32'd0);
    check("reset_state", {29'd0, bus.state_dbg}, {29'd0, ST_IDLE});
    resetn = 1'b1;
    tick();

    // Unlock with the factory code.
    exp_q.push_back(4'b0110);
    if (RELOCK) exp_q.push_back(4'b0110);
    run_op(2'b00, 4'b0110, 4'b0000, 1'b0, 40);
    check("unlock_done", {31'd0, got_done}, 32'd1);
    check("unlock_success", {31'd0, got_success}, 32'd1);
    check("unlock_pulse_cyc", pulse_cyc, 2);
    check("unlock_done_cyc", done_cyc, RELOCK ? 14 : 4);
    check("unlock_n_enter", n_enter, RELOCK ? 2 : 1);
    check("unlock_n_change", n_change, 0);
    check("unlock_open", {31'd0, bus.open_i}, RELOCK ? 32'd0 : 32'd1);
    check("unlock_busy", {31'd0, bus.busy}, 32'd0);
    tick();

`ifndef COMBO_DIALER_RELOCK_EN
    exp_q.push_back(4'b0110);
    run_op(2'b10, 4'b1111, 4'b0000, 1'b0, 40);
    check("relock1_success", {31'd0, got_success}, 32'd1);
    check("relock1_done_cyc", done_cyc, 4);
    check("relock1_open", {31'd0, bus.open_i}, 32'd0);
    tick();
`endif

    // Change code 0110 -> 1001.
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b1001);
    run_op(2'b01, 4'b0110, 4'b1001, 1'b0, 40);
    check("chg_success", {31'd0, got_success}, 32'd1);
    check("chg_n_change", n_change, 1);
    check("chg_n_enter", n_enter, 1);
    check("chg_done_cyc", done_cyc, 8);
    check("chg_code_o", {28'd0, bus.code_o}, 32'h9);
    check("chg_new_i", {31'd0, bus.new_i}, 32'd0);
    tick();

    // New code opens the lock.
    exp_q.push_back(4'b1001);
    if (RELOCK) exp_q.push_back(4'b1001);
    run_op(2'b00, 4'b1001, 4'b0000, 1'b0, 40);
    check("unlock2_success", {31'd0, got_success}, 32'd1);
    check("unlock2_open", {31'd0, bus.open_i}, RELOCK ? 32'd0 : 32'd1);
    tick();

`ifndef COMBO_DIALER_RELOCK_EN
    exp_q.push_back(4'b1001);
    run_op(2'b10, 4'b0000, 4'b0000, 1'b0, 40);
    check("relock2_success", {31'd0, got_success}, 32'd1);
    tick();
`endif

    // Reserved op is ignored.
    bus.op = 2'b11; bus.code_in = 4'b0110; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    act = int'(bus.enter_pulse) + int'(bus.change_pulse) + int'(bus.busy) + int'(bus.done);
    watch(8, act);
    check("rsvd_quiet", act, 0);

    // Wrong code with start held through WAIT: one pulse, timeout.
    exp_q.push_back(4'b0011);
    run_op(2'b00, 4'b0011, 4'b0000, 1'b1, 40);
    check("to_done", {31'd0, got_done}, 32'd1);
    check("to_success", {31'd0, got_success}, 32'd0);
    check("to_done_cyc", done_cyc, 7);
    check("to_n_enter", n_enter, 1);
    check("to_fail_pending", {31'd0, bus.fail_pending}, 32'd1);
    tick();
    bus.start = 1'b0;
    check("start_at_done_ignored", {31'd0, bus.busy}, 32'd0);
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    watch(6, act);
    check("to_quiet", act, 0);

    // Reset while in SETTLE.
    bus.op = 2'b00; bus.code_in = 4'b1001; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("settle_busy", {31'd0, bus.busy}, 32'd1);
    resetn = 1'b0;
    tick();
    check("midrst_outs", {21'd0, outs()}, 32'd0);
    check("midrst_state", {29'd0, bus.state_dbg}, {29'd0, ST_IDLE});
    resetn = 1'b1;
    watch(6, act);
    check("midrst_quiet", act, 0);

    // Two wrong attempts: timeout, then alarm and lockout.
    exp_q.push_back(4'b0011);
    run_op(2'b00, 4'b0011, 4'b0000, 1'b0, 40);
    check("wrong1_success", {31'd0, got_success}, 32'd0);
    check("wrong1_fail_pending", {31'd0, bus.fail_pending}, 32'd1);
    tick();
    exp_q.push_back(4'b0011);
    run_op(2'b00, 4'b0011, 4'b0000, 1'b0, 40);
    check("alarm_done", {31'd0, got_done}, 32'd1);
    check("alarm_done_cyc", done_cyc, 4);
    check("alarm_success", {31'd0, got_success}, 32'd0);
    check("alarm_lockout", {31'd0, bus.lockout}, 32'd1);
    check("alarm_busy", {31'd0, bus.busy}, 32'd0);

    // Requests in lockout do nothing.
    bus.op = 2'b00; bus.code_in = 4'b0110; bus.start = 1'b1;
    watch(8, act);
    bus.start = 1'b0;
    check("lockout_quiet", act, 0);
    check("lockout_held", {31'd0, bus.lockout}, 32'd1);
    check("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
